// File: rtl/lock_access_ctrl_pkg.sv
// Shared types and helpers for the serial keypad lock controller.
// Holds the FSM state encoding, the fail counter width and a clog2 helper.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_t;

    localparam int FAIL_W = 4;

    // Ceiling log2, never less than 1 so a vector always has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lock_access_ctrl_if.sv
// Keypad-side and actuator-side signal bundle of the lock controller.
// slave: controller view (keys in, status out); master: keypad/actuator view.
// With LOCK_CODE_PROG_EN defined, code_wr/code_in are added for code programming.
interface lock_access_ctrl_if
    import lock_pkg::*;
#(
    parameter int CODE_LEN = 4
) ();
    localparam int ENTRY_W = clog2(CODE_LEN + 1);

    logic                key_valid;
    logic                key_bit;
    logic                cancel;
`ifdef LOCK_CODE_PROG_EN
    logic                code_wr;
    logic [CODE_LEN-1:0] code_in;
`endif
    logic                unlock;
    logic                alarm;
    logic                busy;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [ENTRY_W-1:0]  entry_cnt;

    modport slave (
        input  key_valid, key_bit, cancel,
`ifdef LOCK_CODE_PROG_EN
        input  code_wr, code_in,
`endif
        output unlock, alarm, busy, fail_cnt, entry_cnt
    );

    modport master (
        output key_valid, key_bit, cancel,
`ifdef LOCK_CODE_PROG_EN
        output code_wr, code_in,
`endif
        input  unlock, alarm, busy, fail_cnt, entry_cnt
    );

endinterface

// File: rtl/lock_access_ctrl_timer.sv
// lock_timer: loadable down-counter shared by the OPEN and LOCKOUT windows.
// Ports: clk, rst (async, active-low), i_load, i_load_val, o_done (count==0).
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Stops at zero rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/lock_access_ctrl.sv
// lock_access_ctrl: collects bit-serial key entries, compares with the code,
// holds unlock for OPEN_CYCLES and enters an alarmed lockout after MAX_FAILS
// consecutive bad entries. Ports: clk, rst (async, active-low), bus (slave).
// Optional macro LOCK_CODE_PROG_EN: code register writable while OPEN.
module lock_access_ctrl
    import lock_pkg::*;
#(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  OPEN_CYCLES    = 8,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    lock_access_ctrl_if.slave bus
);

    localparam int ENTRY_W = clog2(CODE_LEN + 1);
    localparam int TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ?
                             OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = clog2(TMR_MAX);

    lock_state_t         r_state;
    lock_state_t         w_state_nxt;
    logic [CODE_LEN-2:0] r_shift;
    logic [CODE_LEN-2:0] w_shift_nxt;
    logic [ENTRY_W-1:0]  r_entry_cnt;
    logic [ENTRY_W-1:0]  w_entry_nxt;
    logic [FAIL_W-1:0]   r_fail_cnt;
    logic [FAIL_W-1:0]   w_fail_nxt;
    logic [CODE_LEN-1:0] w_entry;
    logic [CODE_LEN-1:0] w_code;
    logic                w_last;
    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_val;
    logic                w_tmr_done;

`ifdef LOCK_CODE_PROG_EN
    logic [CODE_LEN-1:0] r_code;

    // A write on the final OPEN cycle still lands: it is sampled while
    // the registered state is still OPEN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code <= CODE;
        end else if (bus.code_wr && (r_state == OPEN)) begin
            r_code <= bus.code_in;
        end
    end

    assign w_code = r_code;
`else
    assign w_code = CODE;
`endif

    // Full entry as it would stand after shifting in the current bit.
    assign w_entry = {r_shift, bus.key_bit};
    assign w_last  = (r_entry_cnt == ENTRY_W'(CODE_LEN - 1));

    lock_timer #(
        .W          (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_entry_cnt <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_entry_cnt <= w_entry_nxt;
            r_fail_cnt  <= w_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_entry_nxt = r_entry_cnt;
        w_fail_nxt  = r_fail_cnt;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        unique case (r_state)
            IDLE, ENTRY: begin
                // cancel only aborts a partial entry; in IDLE it is inert.
                if ((r_state == ENTRY) && bus.cancel) begin
                    w_state_nxt = IDLE;
                    w_shift_nxt = '0;
                    w_entry_nxt = '0;
                end else if (bus.key_valid) begin
                    if (w_last) begin
                        w_shift_nxt = '0;
                        w_entry_nxt = '0;
                        w_tmr_load  = 1'b1;
                        if (w_entry == w_code) begin
                            w_state_nxt = OPEN;
                            w_fail_nxt  = '0;
                            w_tmr_val   = TMR_W'(OPEN_CYCLES - 1);
                        end else if (r_fail_cnt >=
                                     FAIL_W'(MAX_FAILS - 1)) begin
                            w_state_nxt = LOCKOUT;
                            w_fail_nxt  = FAIL_W'(MAX_FAILS);
                            w_tmr_val   = TMR_W'(LOCKOUT_CYCLES - 1);
                        end else begin
                            w_state_nxt = IDLE;
                            w_fail_nxt  = r_fail_cnt + FAIL_W'(1);
                            w_tmr_load  = 1'b0;
                        end
                    end else begin
                        w_state_nxt = ENTRY;
                        w_shift_nxt = w_entry[CODE_LEN-2:0];
                        w_entry_nxt = r_entry_cnt + ENTRY_W'(1);
                    end
                end
            end
            OPEN: begin
                if (w_tmr_done) begin
                    w_state_nxt = IDLE;
                end
            end
            LOCKOUT: begin
                if (w_tmr_done) begin
                    w_state_nxt = IDLE;
                    w_fail_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.unlock    = (r_state == OPEN);
    assign bus.alarm     = (r_state == LOCKOUT);
    assign bus.busy      = bus.unlock | bus.alarm;
    assign bus.fail_cnt  = r_fail_cnt;
    assign bus.entry_cnt = r_entry_cnt;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Directed vector bench for lock_access_ctrl (CODE 1011, 3 fails, 8/16 cycles).
// Vectors carry inputs and the expected outputs after the sampling edge.
module tb_lock_access_ctrl;

    typedef struct {
        logic       kv;
        logic       kb;
        logic       cn;
        logic       cw;
        logic [3:0] ci;
        logic       u;
        logic       a;
        logic [3:0] f;
        logic [2:0] e;
        string      nm;
    } vec_t;

    logic clk;
    logic rst;
    int   nvec;
    int   nmis;
    vec_t vq[$];

    lock_access_ctrl_if #(.CODE_LEN(4)) bus ();

    lock_access_ctrl #(
        .CODE_LEN       (4),
        .CODE           (4'b1011),
        .MAX_FAILS      (3),
        .OPEN_CYCLES    (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void pv(input logic kv, input logic kb,
                               input logic cn, input logic cw,
                               input logic [3:0] ci, input logic u,
                               input logic a, input logic [3:0] f,
                               input logic [2:0] e, input string nm);
        vec_t v;
        v.kv = kv; v.kb = kb; v.cn = cn; v.cw = cw; v.ci = ci;
        v.u = u; v.a = a; v.f = f; v.e = e; v.nm = nm;
        vq.push_back(v);
    endfunction

    function automatic void p(input logic kv, input logic kb,
                              input logic cn, input logic u,
                              input logic a, input logic [3:0] f,
                              input logic [2:0] e, input string nm);
        pv(kv, kb, cn, 1'b0, 4'd0, u, a, f, e, nm);
    endfunction

    // n idle cycles with constant expected outputs
    function automatic void pw(input int n, input logic u, input logic a,
                               input logic [3:0] f, input string nm);
        for (int i = 0; i < n; i++) p(0, 0, 0, u, a, f, 3'd0, nm);
    endfunction

    // A 4-bit entry of idle-state keys: entry_cnt 1,2,3 then the outcome.
    function automatic void pe(input logic [3:0] k, input logic [3:0] f0,
                               input logic u, input logic a,
                               input logic [3:0] f1, input string nm);
        logic [3:0] kk;
        kk = k;
        p(1, kk[3], 0, 0, 0, f0, 3'd1, {nm, "_b1"});
        p(1, kk[2], 0, 0, 0, f0, 3'd2, {nm, "_b2"});
        p(1, kk[1], 0, 0, 0, f0, 3'd3, {nm, "_b3"});
        p(1, kk[0], 0, u, a, f1, 3'd0, {nm, "_end"});
    endfunction

    task automatic check(input string nm, input logic u, input logic a,
                         input logic [3:0] f, input logic [2:0] e);
        logic b;
        b = u | a;
        nvec++;
        if (bus.unlock !== u || bus.alarm !== a || bus.busy !== b ||
            bus.fail_cnt !== f || bus.entry_cnt !== e) begin
            nmis++;
            $display("FAIL %s: got u=%b a=%b b=%b f=%0d e=%0d want u=%b a=%b b=%b f=%0d e=%0d",
                     nm, bus.unlock, bus.alarm, bus.busy, bus.fail_cnt,
                     bus.entry_cnt, u, a, b, f, e);
        end
    endtask

    task automatic run_all();
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            bus.key_valid = vq[i].kv;
            bus.key_bit   = vq[i].kb;
            bus.cancel    = vq[i].cn;
`ifdef LOCK_CODE_PROG_EN
            bus.code_wr   = vq[i].cw;
            bus.code_in   = vq[i].ci;
`endif
            @(posedge clk);
            #1;
            check(vq[i].nm, vq[i].u, vq[i].a, vq[i].f, vq[i].e);
        end
        vq.delete();
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_bit   = 1'b0;
        bus.cancel    = 1'b0;
`ifdef LOCK_CODE_PROG_EN
        bus.code_wr   = 1'b0;
`endif
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        rst  = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_bit   = 1'b0;
        bus.cancel    = 1'b0;
`ifdef LOCK_CODE_PROG_EN
        bus.code_wr   = 1'b0;
        bus.code_in   = 4'd0;
`endif
        #12;
        check("reset", 0, 0, 4'd0, 3'd0);
        @(negedge clk);
        rst = 1'b1;

        // correct code, unlock held 8 cycles, keys ignored while open
        pe(4'b1011, 0, 1, 0, 0, "t1");
        p(1, 1, 0, 1, 0, 0, 0, "t1_ign1");
        p(1, 0, 0, 1, 0, 0, 0, "t1_ign0");
        p(1, 1, 1, 1, 0, 0, 0, "t1_ign1c");
        p(1, 1, 0, 1, 0, 0, 0, "t1_ign1");
        pw(3, 1, 0, 0, "t1_open");
        pw(1, 0, 0, 0, "t1_close");

        // three bad entries -> lockout 16 cycles, keys ignored
        pe(4'b1111, 0, 0, 0, 1, "t2_e1");
        pe(4'b1111, 1, 0, 0, 2, "t2_e2");
        pe(4'b1111, 2, 0, 1, 3, "t2_e3");
        p(1, 1, 0, 0, 1, 3, 0, "t2_ign1");
        p(1, 0, 0, 0, 1, 3, 0, "t2_ign0");
        p(1, 1, 1, 0, 1, 3, 0, "t2_ign1c");
        p(1, 1, 0, 0, 1, 3, 0, "t2_ign1");
        pw(11, 0, 1, 3, "t2_lock");
        pw(1, 0, 0, 0, "t2_release");

        // partial entry cancelled, then the right code
        p(1, 1, 0, 0, 0, 0, 1, "t3_b1");
        p(1, 0, 0, 0, 0, 0, 2, "t3_b2");
        p(0, 0, 1, 0, 0, 0, 0, "t3_cancel");
        pe(4'b1011, 0, 1, 0, 0, "t3");
        pw(7, 1, 0, 0, "t3_open");
        pw(1, 0, 0, 0, "t3_close");

        // cancel and key together mid-entry: bit discarded
        p(1, 1, 0, 0, 0, 0, 1, "t4_b1");
        p(1, 0, 0, 0, 0, 0, 2, "t4_b2");
        p(1, 1, 1, 0, 0, 0, 0, "t4_cancel_key");
        pe(4'b1011, 0, 1, 0, 0, "t4");
        pw(7, 1, 0, 0, "t4_open");
        pw(1, 0, 0, 0, "t4_close");

        // fail count survives cancel, clears on a match
        pe(4'b0000, 0, 0, 0, 1, "t5_bad");
        p(0, 0, 1, 0, 0, 1, 0, "t5_idle_cancel");
        p(1, 1, 0, 0, 0, 1, 1, "t5_b1");
        p(1, 0, 0, 0, 0, 1, 2, "t5_b2");
        p(0, 0, 1, 0, 0, 1, 0, "t5_cancel");
        pe(4'b1011, 1, 1, 0, 0, "t5");
        pw(7, 1, 0, 0, "t5_open");
        pw(1, 0, 0, 0, "t5_close");
        run_all();

        // async reset in the middle of lockout
        pe(4'b0001, 0, 0, 0, 1, "t6_e1");
        pe(4'b0001, 1, 0, 0, 2, "t6_e2");
        pe(4'b0001, 2, 0, 1, 3, "t6_e3");
        pw(3, 0, 1, 3, "t6_lock");
        run_all();
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_mid_lockout", 0, 0, 4'd0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        pe(4'b1011, 0, 1, 0, 0, "t6_after");
        pw(7, 1, 0, 0, "t6_open");
        pw(1, 0, 0, 0, "t6_close");
        run_all();

`ifdef LOCK_CODE_PROG_EN
        // write in IDLE ignored; write on final OPEN cycle lands
        pv(0, 0, 0, 1, 4'b0110, 0, 0, 0, 0, "p_idle_wr");
        pe(4'b1011, 0, 1, 0, 0, "p_old");
        pw(7, 1, 0, 0, "p_open");
        pv(0, 0, 0, 1, 4'b0110, 0, 0, 0, 0, "p_last_wr");
        pe(4'b1011, 0, 0, 0, 1, "p_oldfail");
        pe(4'b0110, 1, 1, 0, 0, "p_new");
        pw(7, 1, 0, 0, "p_open2");
        pw(1, 0, 0, 0, "p_close2");
        run_all();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/lock_access_ctrl.md
Name: lock_access_ctrl

Overview:
Sequencing controller for the serial keypad lock. It collects bit-serial key entries, compares each complete entry against the stored code, and holds the door-open output for a timed window. It counts consecutive failed entries and enters a timed lockout with an alarm once the limit is reached. It sits between the keypad front-end and the door actuator/alarm logic.

Parameters:
CODE_LEN, 4, number of key bits per entry (2..16)
CODE, 4'b1011, reset/default unlock code, compared MSB-first (first key bit entered = MSB)
MAX_FAILS, 3, consecutive failed entries that trigger lockout (1..15)
OPEN_CYCLES, 8, clk cycles unlock stays high (>=1)
LOCKOUT_CYCLES, 16, clk cycles lockout lasts (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
key_valid  in  1  key_bit is valid this cycle
key_bit  in  1  entered key bit
cancel  in  1  abort the current partial entry
unlock  out  1  door open, registered
alarm  out  1  lockout active, registered
busy  out  1  high in OPEN or LOCKOUT; key entries are ignored while high
fail_cnt  out  4  consecutive failed entries, saturating at MAX_FAILS
entry_cnt  out  clog2(CODE_LEN+1)  bits collected in the current entry

Behaviour:
- Reset (rst=0, async): state=IDLE, shift register=0, entry_cnt=0, fail_cnt=0, timer=0, unlock=0, alarm=0, busy=0.
- Reset mid-OPEN or mid-LOCKOUT aborts immediately: outputs clear and fail_cnt is lost.
- States: IDLE, ENTRY, OPEN, LOCKOUT.
- IDLE: key_valid=1 shifts key_bit in, sets entry_cnt=1 and moves to ENTRY. If CODE_LEN reaches 1, the entry is evaluated the same way as in ENTRY.
- ENTRY: each key_valid shifts key_bit into the LSB and increments entry_cnt. key_valid=0 holds state; there is no inter-key timeout.
- Entry complete: the edge that samples bit number CODE_LEN evaluates {shift[CODE_LEN-2:0], key_bit} against the code.
  - Match: go to OPEN. unlock=1 from the next cycle for exactly OPEN_CYCLES cycles. fail_cnt clears to 0.
  - Mismatch with fail_cnt+1 < MAX_FAILS: fail_cnt increments and the state returns to IDLE.
  - Mismatch with fail_cnt+1 = MAX_FAILS: fail_cnt=MAX_FAILS, go to LOCKOUT. alarm=1 from the next cycle for exactly LOCKOUT_CYCLES cycles.
  - In all three cases, entry_cnt and the shift register clear.
- cancel in ENTRY: clears the shift register and entry_cnt, returns to IDLE, and fail_cnt is unchanged. cancel in IDLE, OPEN or LOCKOUT has no effect.
- cancel and key_valid in the same cycle: cancel wins and the bit is discarded.
- OPEN: the timer loads OPEN_CYCLES-1 on entry and decrements each cycle. At timer=0 the next state is IDLE and unlock falls. key_valid is ignored.
- LOCKOUT: the timer loads LOCKOUT_CYCLES-1 and decrements each cycle. At timer=0 the next state is IDLE, alarm falls and fail_cnt clears to 0. key_valid is ignored.
- Timer width: clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)). The timer does not wrap; it stops at 0.
- Sequences overlapping an entry boundary are not detected. Entries are fixed-length blocks, not a sliding match.
- Outputs are Moore, decoded from registered state: unlock = (state==OPEN), alarm = (state==LOCKOUT), busy = unlock|alarm.

Optional Feature:
LOCK_CODE_PROG_EN
- Defined: adds ports code_wr (in, 1) and code_in (in, CODE_LEN).
  - A code register resets to CODE and is used for comparison.
  - code_wr=1 while state==OPEN loads code_in on that edge. code_wr in any other state is ignored.
  - A write in the final OPEN cycle still takes effect.
- Not defined: the ports are absent and the compare uses the CODE constant.

Decomposition:
- Package lock_pkg holds:
  - state encoding typedef: IDLE=2'd0, ENTRY=2'd1, OPEN=2'd2, LOCKOUT=2'd3
  - fail_cnt width constant (4)
  - width helper function (clog2)
- Sub-module lock_timer: loadable down-counter with load, load_val, and done (=count==0). One instance is shared by OPEN and LOCKOUT, since the two are mutually exclusive.

Test Plan:
- Reset, then bits 1,0,1,1 on consecutive cycles -> unlock=1 starting the cycle after the 4th bit, held exactly 8 cycles; fail_cnt=0; busy=1 throughout.
- Bits 1,1,1,1 three times -> fail_cnt steps 1,2,3; alarm=1 for exactly 16 cycles after the 3rd entry; then fail_cnt=0 and state=IDLE.
- Bits 1,0 then cancel, then 1,0,1,1 -> unlock asserts; fail_cnt stays 0; entry_cnt shows 0 after the cancel.
- During OPEN and LOCKOUT apply key_valid with bits 1,0,1,1 -> ignored; entry_cnt stays 0 and no extra unlock.
- cancel and key_valid in the same cycle mid-entry -> bit discarded, entry_cnt=0. Also drop rst mid-LOCKOUT -> alarm=0 and fail_cnt=0 immediately.
- LOCK_CODE_PROG_EN: in OPEN, write code_in=4'b0110 -> next entry 1,0,1,1 fails and 0,1,1,0 unlocks. A code_wr in IDLE leaves the code unchanged.
